// File: rtl/mux8x1_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux8x1_rr_arbiter
//   Round-robin arbiter and select controller for a shared 8:1 mux.
//   Eight requesters compete; one owner at a time drives the mux select lines
//   with its index. Ownership ends when the owner drops its request, or when
//   the hold limit is reached while another requester is waiting.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous reset, active-low
//   req[7:0]   in   level request per requester (bit k <-> mux input k)
//   gnt[7:0]   out  one-hot registered grant, zero when idle
//   s0,s1,s2   out  registered mux select (owner index, s2 = MSB)
//   sel_valid  out  high while gnt is non-zero
//
// Parameter
//   MAX_HOLD   max consecutive cycles an owner keeps the grant while someone
//              else waits; 0 disables preemption (legal 0..255)
// -----------------------------------------------------------------------------
module mux8x1_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic       sel_valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  state_t     state, state_nxt;
  logic [2:0] ptr, ptr_nxt;
  logic [2:0] sel, sel_nxt;
  logic [7:0] gnt_nxt;
  logic       vld_nxt;
  logic [7:0] hold_cnt, hold_nxt;

  logic [7:0] others;
  logic [3:0] pick_any;
  logic [3:0] pick_oth;
  logic       take;
  logic [2:0] take_idx;

  // Returns {found, index} of the first set bit of r searching p+1, p+2, ...
  // with wrap-around; p itself is examined last.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0000;
    for (int i = 1; i <= 8; i++) begin
      idx = p + 3'(i);
      if (!res[3] && r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign others   = req & ~(8'b1 << ptr);
  assign pick_any = rr_pick(req, ptr);
  assign pick_oth = rr_pick(others, ptr);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    sel_nxt   = sel;
    gnt_nxt   = gnt;
    vld_nxt   = sel_valid;
    hold_nxt  = hold_cnt;
    take      = 1'b0;
    take_idx  = 3'd0;

    case (state)
      IDLE: begin
        if (pick_any[3]) begin
          take     = 1'b1;
          take_idx = pick_any[2:0];
        end
      end
      GRANT: begin
        if (!req[ptr]) begin
          // Owner released: hand over directly if anyone else is waiting.
          if (pick_oth[3]) begin
            take     = 1'b1;
            take_idx = pick_oth[2:0];
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = 8'h00;
            vld_nxt   = 1'b0;
            hold_nxt  = 8'd0;
          end
        end else if ((HOLD_LIM != 8'd0) && (hold_cnt == HOLD_LIM) && pick_oth[3]) begin
          // Preemption: the owner is excluded, so it only re-wins when the
          // rotation comes back around to it.
          take     = 1'b1;
          take_idx = pick_oth[2:0];
        end else if (hold_cnt < HOLD_LIM) begin
          hold_nxt = hold_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (take) begin
      state_nxt = GRANT;
      ptr_nxt   = take_idx;
      sel_nxt   = take_idx;
      gnt_nxt   = 8'b1 << take_idx;
      vld_nxt   = 1'b1;
      hold_nxt  = 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 3'd7;
      sel       <= 3'd0;
      gnt       <= 8'h00;
      sel_valid <= 1'b0;
      hold_cnt  <= 8'd0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      sel       <= sel_nxt;
      gnt       <= gnt_nxt;
      sel_valid <= vld_nxt;
      hold_cnt  <= hold_nxt;
    end
  end

  assign s0 = sel[0];
  assign s1 = sel[1];
  assign s2 = sel[2];

endmodule

// File: tb/tb_mux8x1_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux8x1_rr_arbiter
//   Directed bench for mux8x1_rr_arbiter. Two instances share the stimulus:
//   dut_a with MAX_HOLD=4 and dut_b with MAX_HOLD=1. Each step drives inputs,
//   pushes the outputs expected after the next rising edge, then pops and
//   compares them against the selected instance.
// -----------------------------------------------------------------------------
module tb_mux8x1_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;

  logic [7:0] gnt_a, gnt_b;
  logic       s0_a, s1_a, s2_a, s0_b, s1_b, s2_b;
  logic       vld_a, vld_b;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [7:0] g;
    logic [2:0] s;
    logic       v;
    bit         on_b;
  } exp_t;

  exp_t sb[$];

  mux8x1_rr_arbiter #(.MAX_HOLD(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt_a),
    .s0(s0_a), .s1(s1_a), .s2(s2_a), .sel_valid(vld_a)
  );

  mux8x1_rr_arbiter #(.MAX_HOLD(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt_b),
    .s0(s0_b), .s1(s1_b), .s2(s2_b), .sel_valid(vld_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic step(input logic rn, input logic [7:0] r, input logic [7:0] eg,
                      input logic [2:0] es, input logic ev, input bit on_b,
                      input string tag);
    exp_t e;
    exp_t got;
    logic [7:0] og;
    logic [2:0] os;
    logic       ov;
    rst_n = rn;
    req   = r;
    e.tag = tag; e.g = eg; e.s = es; e.v = ev; e.on_b = on_b;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL %s scoreboard empty", tag);
      return;
    end
    got = sb.pop_front();
    og = got.on_b ? gnt_b : gnt_a;
    os = got.on_b ? {s2_b, s1_b, s0_b} : {s2_a, s1_a, s0_a};
    ov = got.on_b ? vld_b : vld_a;
    assert (og === got.g) else begin
      failures++;
      $error("FAIL %s gnt observed=%h expected=%h", got.tag, og, got.g);
    end
    checks++;
    assert (os === got.s) else begin
      failures++;
      $error("FAIL %s sel observed=%0d expected=%0d", got.tag, os, got.s);
    end
    checks++;
    assert (ov === got.v) else begin
      failures++;
      $error("FAIL %s sel_valid observed=%b expected=%b", got.tag, ov, got.v);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    #1;

    // Reset state, then idle with no requests.
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, "reset");
    for (int i = 0; i < 5; i++)
      step(1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, "idle");

    // Two requesters 0 and 7, MAX_HOLD=4: 4 cycles each, rotating.
    for (int i = 0; i < 4; i++)
      step(1'b1, 8'h81, 8'h01, 3'd0, 1'b1, 1'b0, "rot_own0");
    for (int i = 0; i < 4; i++)
      step(1'b1, 8'h81, 8'h80, 3'd7, 1'b1, 1'b0, "rot_own7");
    for (int i = 0; i < 2; i++)
      step(1'b1, 8'h81, 8'h01, 3'd0, 1'b1, 1'b0, "rot_back0");

    // Lone owner 3 is never preempted; release goes idle, select holds.
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, "reset2");
    for (int i = 0; i < 20; i++)
      step(1'b1, 8'h08, 8'h08, 3'd3, 1'b1, 1'b0, "hold3");
    step(1'b1, 8'h00, 8'h00, 3'd3, 1'b0, 1'b0, "release3");
    step(1'b1, 8'h00, 8'h00, 3'd3, 1'b0, 1'b0, "idle_after3");

    // Owner 5 releases as 2 requests: direct hand-over, no bubble.
    step(1'b1, 8'h20, 8'h20, 3'd5, 1'b1, 1'b0, "own5");
    step(1'b1, 8'h04, 8'h04, 3'd2, 1'b1, 1'b0, "handover2");
    step(1'b1, 8'h00, 8'h00, 3'd2, 1'b0, 1'b0, "release2");

    // All requesting with MAX_HOLD=1: one cycle each, 0..7 then wrap to 0.
    step(1'b0, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b1, "reset_b");
    for (int i = 0; i < 8; i++)
      step(1'b1, 8'hFF, 8'h01 << i, 3'(i), 1'b1, 1'b1, "all_ff");
    step(1'b1, 8'hFF, 8'h01, 3'd0, 1'b1, 1'b1, "all_ff_wrap");

    // Reset mid-grant at index 6, then restart with everyone requesting.
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, "reset3");
    step(1'b1, 8'h40, 8'h40, 3'd6, 1'b1, 1'b0, "own6");
    step(1'b1, 8'h40, 8'h40, 3'd6, 1'b1, 1'b0, "own6_hold");
    step(1'b0, 8'h40, 8'h00, 3'd0, 1'b0, 1'b0, "reset_mid");
    step(1'b1, 8'hFF, 8'h01, 3'd0, 1'b1, 1'b0, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux8x1_rr_arbiter.md
Name: mux8x1_rr_arbiter

Overview:
- Round-robin arbiter and select controller for the shared 8:1 gate-level mux.
- Eight requesters compete for the mux. The block grants one at a time, drives the mux select lines s2..s0 with the owner's index, and flags when the select is valid.
- Ownership lasts until the requester drops its request, or until a hold limit expires while others are waiting.
- Sits between requester logic and the mux select inputs; the mux datapath itself is unchanged.

Parameters:
- MAX_HOLD, 4: maximum consecutive cycles one owner keeps the grant while another requester waits. 0 disables preemption. Legal range 0..255.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- req  input  8  level request per requester; bit k pairs with mux input ik
- gnt  output  8  one-hot grant, registered; all-zero when idle
- s0  output  1  mux select bit 0 (LSB of owner index), registered
- s1  output  1  mux select bit 1, registered
- s2  output  1  mux select bit 2 (MSB), registered
- sel_valid  output  1  high while gnt is non-zero; s2..s0 are meaningful only when high

Behaviour:
- Reset (rst_n low at a clk edge), applied on that same edge regardless of state:
  - gnt=0, s2..s0=000, sel_valid=0, state IDLE.
  - Priority pointer ptr=7, so index 0 has first priority.
  - hold_cnt=0.
- Reset mid-grant: grant drops on that edge with no completion cycle.
- State IDLE:
  - If req==0, stay in IDLE. Outputs hold: gnt=0, sel_valid=0, s2..s0 keep their last value.
  - If req!=0, pick k = first set bit of req searching ptr+1, ptr+2, ... with wrap 7->0.
  - Next edge: gnt=1<<k, {s2,s1,s0}=k, sel_valid=1, ptr=k, hold_cnt=1, state GRANT.
  - Latency from request to grant is 1 cycle.
- State GRANT, owner k. Evaluate each cycle in this order:
  1. req[k]==0 (release):
     - If other requests are pending, hand over directly on the next edge to the next requester after k (round-robin from ptr=k). No idle bubble.
     - If none are pending, go to IDLE on the next edge (gnt=0, sel_valid=0).
  2. MAX_HOLD!=0, hold_cnt==MAX_HOLD, and (req & ~(1<<k))!=0 (preemption): hand over to the next requester after k. The preempted owner may re-win later in rotation.
  3. Otherwise keep the grant. hold_cnt increments, saturating at MAX_HOLD, and saturates with no effect when there is no contender.
- Every new grant sets ptr=new owner and hold_cnt=1.
- hold_cnt is 8 bits, unsigned.
- Output invariants, every cycle:
  - gnt is one-hot or zero.
  - sel_valid == |gnt.
  - When sel_valid=1, {s2,s1,s0} equals the index of the set gnt bit.
  - gnt and s2..s0 update on the same edge, so the mux never sees a select that mismatches gnt.
- Simultaneous release by the owner and a new request elsewhere: the new requester is granted on the next edge.
- Owner requests again in the same cycle it is preempted: it is not eligible until the rotation returns to it.
- X on req is not handled; the bench drives only 0/1.

Test Plan:
- Reset, then req=8'h00 for 5 cycles -> gnt=0, sel_valid=0, {s2,s1,s0}=000 throughout.
- From reset, req=8'b1000_0001 held -> 1 cycle later gnt=8'h01, sel=000. After 4 cycles (MAX_HOLD=4) gnt=8'h80, sel=111. 4 cycles later gnt=8'h01 again; the rotation continues.
- Owner index 3 granted, others idle; req[3] held 20 cycles -> gnt stays 8'h08, sel=011, no preemption. Drop req[3] -> next edge gnt=0, sel_valid=0, sel holds 011.
- Owner index 5; in one cycle req[5]=0 and req[2]=1 -> next edge gnt=8'h04, sel=010, sel_valid stays 1 (no bubble).
- All req=8'hFF with MAX_HOLD=1 -> grants cycle 0,1,2,...,7,0, one cycle each. sel counts 000..111 and wraps.
- Grant active at index 6; pull rst_n low for 1 cycle -> that edge gnt=0, sel=000, sel_valid=0. After release with req=8'hFF -> first grant is index 0.
